// File: rtl/carrier_nco.sv
// Numerically controlled oscillator for the carrier path: a phase accumulator with
// glitch-free frequency-word changes at the wrap, phase sync, offset/invert and a gate window.
module carrier_nco #(
  parameter int ACC_WIDTH = 51,
  parameter int PHASE_BITS = 5,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'(64'd207992122400030)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ACC_WIDTH-1:0]  inc_data,
  input  logic                  inc_valid,
  output logic                  inc_ready,
  input  logic                  phase_sync,
  input  logic [PHASE_BITS-1:0] phase_offset,
  input  logic                  invert,
  input  logic                  gate_start,
  input  logic [7:0]            gate_len,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  phase_valid,
  output logic                  gate_active
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [PHASE_BITS-1:0] HALF_CYCLE = {1'b1, {(PHASE_BITS-1){1'b0}}};

  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_inc;
  logic [ACC_WIDTH-1:0]  r_inc_pend;
  logic [0:0]            r_state;
  logic [7:0]            r_gcnt;
  logic [PHASE_BITS-1:0] r_phase;
  logic                  r_phase_valid;
  logic                  r_gate_active;

  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_carry;
  logic                  w_wrap;
  logic                  w_apply;
  logic                  w_accept;
  logic [PHASE_BITS-1:0] w_phase_next;
  logic [7:0]            w_gcnt_next;

  assign w_sum    = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_carry  = w_sum[ACC_WIDTH];
  assign w_wrap   = enable & w_carry & (r_state == ST_PENDING);
  // A pending word is applied either at the accumulator wrap or on a phase sync.
  assign w_apply  = (r_state == ST_PENDING) & (phase_sync | w_wrap);
  assign w_accept = inc_valid & inc_ready;

  assign inc_ready = (r_state == ST_IDLE) & ~rst;

  assign w_phase_next = r_acc[ACC_WIDTH-1 -: PHASE_BITS] + phase_offset
                        + (invert ? HALF_CYCLE : '0);

  always_comb begin
    w_gcnt_next = r_gcnt;
    if (gate_start) begin
      w_gcnt_next = gate_len;
    end else if (r_gcnt != 8'd0) begin
      w_gcnt_next = r_gcnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (phase_sync) begin
      r_acc <= '0;
    end else if (enable) begin
      r_acc <= w_sum[ACC_WIDTH-1:0];
    end
  end

  // The addition in the wrap cycle still uses the old increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc      <= DEFAULT_INC;
      r_inc_pend <= '0;
      r_state    <= ST_IDLE;
    end else if (w_apply) begin
      r_inc   <= r_inc_pend;
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_inc_pend <= inc_data;
      r_state    <= ST_PENDING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
    end else begin
      r_phase       <= w_phase_next;
      r_phase_valid <= enable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcnt        <= 8'd0;
      r_gate_active <= 1'b0;
    end else begin
      r_gcnt        <= w_gcnt_next;
      r_gate_active <= (w_gcnt_next != 8'd0);
    end
  end

  assign phase       = r_phase;
  assign phase_valid = r_phase_valid;
  assign gate_active = r_gate_active;

endmodule

// File: tb/tb_carrier_nco.sv
// Self-checking bench for carrier_nco: directed scenarios plus randomized traffic,
// every cycle compared against an arithmetic reference model.
module tb_carrier_nco;

   localparam int AW = 8;
   localparam int PB = 5;
   localparam int ACC_MOD = 1 << AW;
   localparam int PH_MOD = 1 << PB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic [AW-1:0] inc_data = '0;
   logic inc_valid = 1'b0;
   logic inc_ready;
   logic phase_sync = 1'b0;
   logic [PB-1:0] phase_offset = '0;
   logic invert = 1'b0;
   logic gate_start = 1'b0;
   logic [7:0] gate_len = '0;
   logic [PB-1:0] phase;
   logic phase_valid;
   logic gate_active;

   int checkCount = 0;
   int passCount = 0;

   // reference model state
   int mAcc = 0;
   int mInc = 16;
   int mPend = 0;
   bit mPending = 0;
   int mGcnt = 0;
   int mPhase = 0;
   bit mPhaseValid = 0;
   bit mGateActive = 0;

   carrier_nco #(
      .ACC_WIDTH(AW),
      .PHASE_BITS(PB),
      .DEFAULT_INC(8'd16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .inc_data(inc_data),
      .inc_valid(inc_valid),
      .inc_ready(inc_ready),
      .phase_sync(phase_sync),
      .phase_offset(phase_offset),
      .invert(invert),
      .gate_start(gate_start),
      .gate_len(gate_len),
      .phase(phase),
      .phase_valid(phase_valid),
      .gate_active(gate_active)
   );

   always #5 clk = ~clk;

   // compare one observed value against its expected value and tally the result
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // advance the reference model by one clock edge using the current inputs
   task automatic stepModel();
      int sum;
      bit carry;
      bit acceptNow;
      if (rst) begin
         mAcc = 0; mInc = 16; mPend = 0; mPending = 0; mGcnt = 0;
         mPhase = 0; mPhaseValid = 0; mGateActive = 0;
      end else begin
         sum = mAcc + mInc;
         carry = (sum >= ACC_MOD);
         acceptNow = !mPending && inc_valid;
         mPhase = ((mAcc / (ACC_MOD / PH_MOD)) + int'(phase_offset) + (invert ? PH_MOD / 2 : 0)) % PH_MOD;
         mPhaseValid = enable;
         if (phase_sync) begin
            mAcc = 0;
            if (mPending) begin mInc = mPend; mPending = 0; end
         end else if (enable) begin
            mAcc = sum % ACC_MOD;
            if (mPending && carry) begin mInc = mPend; mPending = 0; end
         end
         if (acceptNow) begin mPend = int'(inc_data); mPending = 1; end
         if (gate_start) mGcnt = int'(gate_len);
         else if (mGcnt > 0) mGcnt = mGcnt - 1;
         mGateActive = (mGcnt != 0);
      end
   endtask

   // drive one cycle of inputs, clock it, then compare all outputs with the model
   task automatic applyStimulus(input bit r, input bit en, input int incD, input bit incV,
                                input bit sync, input int off, input bit inv,
                                input bit gStart, input int gLen);
      @(negedge clk);
      rst = r;
      enable = en;
      inc_data = AW'(incD);
      inc_valid = incV;
      phase_sync = sync;
      phase_offset = PB'(off);
      invert = inv;
      gate_start = gStart;
      gate_len = 8'(gLen);
      stepModel();
      @(posedge clk);
      #1;
      checkOutput("phase", int'(phase), mPhase);
      checkOutput("phase_valid", int'(phase_valid), int'(mPhaseValid));
      checkOutput("gate_active", int'(gate_active), int'(mGateActive));
      checkOutput("inc_ready", int'(inc_ready), int'(!mPending && !rst));
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int activeCycles;

      // reset state
      doReset();
      checkOutput("reset_phase", int'(phase), 0);
      checkOutput("reset_valid", int'(phase_valid), 0);
      checkOutput("reset_gate", int'(gate_active), 0);
      checkOutput("reset_ready", int'(inc_ready), 0);

      // free run with the default increment: phase steps by 2 after one cycle of latency
      for (int k = 1; k <= 18; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
         checkOutput("freerun_phase", int'(phase), (2 * (k - 1)) % 32);
         checkOutput("freerun_valid", int'(phase_valid), 1);
      end

      // frequency change offered at acc=48, applied at the next wrap
      doReset();
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32, 1, 0, 0, 0, 0, 0);
      checkOutput("freq_ready_drop", int'(inc_ready), 0);
      for (int k = 0; k < 24; k++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("freq_ready_back", int'(inc_ready), 1);

      // offset and invert at acc=0
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0);
      checkOutput("offset_invert", int'(phase), 19);

      // acc=248 reached with an increment of 8 after the first wrap
      applyStimulus(0, 0, 8, 1, 0, 3, 1, 0, 0);
      for (int k = 0; k < 16; k++) applyStimulus(0, 1, 0, 0, 0, 3, 1, 0, 0);
      while (mAcc != 248) applyStimulus(0, 1, 0, 0, 0, 3, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0);
      checkOutput("offset_invert_248", int'(phase), 18);

      // sync while pending applies the new word immediately
      doReset();
      applyStimulus(0, 0, 64, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("sync_ready", int'(inc_ready), 1);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
         checkOutput("sync_phase", int'(phase), (8 * (k - 1)) % 32);
      end

      // gate window of 10 cycles
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 10);
      activeCycles = int'(gate_active);
      for (int k = 0; k < 14; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 10);
         activeCycles += int'(gate_active);
      end
      checkOutput("gate_len10", activeCycles, 10);

      // retrigger at count 3 gives 10 more cycles
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 10);
      activeCycles = int'(gate_active);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 10);
         activeCycles += int'(gate_active);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 10);
      activeCycles += int'(gate_active);
      for (int k = 0; k < 14; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 10);
         activeCycles += int'(gate_active);
      end
      checkOutput("gate_retrigger", activeCycles, 17);

      // zero length never opens the gate
      activeCycles = 0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      activeCycles += int'(gate_active);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
         activeCycles += int'(gate_active);
      end
      checkOutput("gate_len0", activeCycles, 0);

      // reset while pending with the gate open
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 64, 1, 0, 0, 0, 1, 10);
      checkOutput("mid_gate_open", int'(gate_active), 1);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_rst_phase", int'(phase), 0);
      checkOutput("mid_rst_valid", int'(phase_valid), 0);
      checkOutput("mid_rst_gate", int'(gate_active), 0);
      checkOutput("mid_rst_ready", int'(inc_ready), 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_release_ready", int'(inc_ready), 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mid_default_inc", int'(phase), 4);

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, ACC_MOD - 1)), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 63) == 0), int'($urandom_range(0, PH_MOD - 1)),
                       ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0),
                       int'($urandom_range(0, 20)));
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/carrier_nco.md
CARRIER_NCO -- requirements
Module: carrier_nco

Interface
REQ-001 Parameter ACC_WIDTH, default 51: phase accumulator width in bits.
REQ-002 Parameter PHASE_BITS, default 5: width of the phase output that feeds the sine table stage.
REQ-003 Parameter DEFAULT_INC, default 207992122400030 (ACC_WIDTH bits): the frequency word loaded at reset.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset; synchronous and active-high.
REQ-006 Port enable, input, 1: when high, the accumulator advances.
REQ-007 Port inc_data, input, ACC_WIDTH: new frequency word.
REQ-008 Port inc_valid, input, 1: inc_data is offered.
REQ-009 Port inc_ready, output, 1: the block accepts inc_data.
REQ-010 Port phase_sync, input, 1: single-cycle pulse that zeroes the accumulator.
REQ-011 Port phase_offset, input, PHASE_BITS: static phase added to the output.
REQ-012 Port invert, input, 1: adds a half-cycle, i.e. 1 shifted left by (PHASE_BITS-1), to the output phase.
REQ-013 Port gate_start, input, 1: pulse that starts a gate window.
REQ-014 Port gate_len, input, 8: gate window length in cycles.
REQ-015 Port phase, output, PHASE_BITS: registered carrier phase.
REQ-016 Port phase_valid, output, 1: phase is advancing this cycle.
REQ-017 Port gate_active, output, 1: the gate window is open.

Function
REQ-018 Accumulator update: acc <= acc + inc when enable=1, modulo 2^ACC_WIDTH; acc holds when enable=0. carry = carry-out of that addition.
REQ-019 phase <= (acc[ACC_WIDTH-1 -: PHASE_BITS] + phase_offset + (invert ? 2^(PHASE_BITS-1) : 0)) mod 2^PHASE_BITS; this is computed from the pre-update acc, so latency from acc is 1 cycle.
REQ-020 phase_valid <= enable, registered, aligned with phase.
REQ-021 Increment FSM has two states, IDLE and PENDING; inc_ready = (state==IDLE) and not in reset.
REQ-022 IDLE: on inc_valid and inc_ready, capture inc_data into inc_pend and go to PENDING; inc is not changed yet.
REQ-023 PENDING: on a cycle where enable=1 and carry=1 (wrap), inc <= inc_pend and go to IDLE. The addition in that cycle uses the old inc.
REQ-024 PENDING with enable=0: remain in PENDING indefinitely; inc_valid is ignored.
REQ-025 phase_sync=1: acc <= 0, overriding the REQ-018 update regardless of enable. If PENDING, inc <= inc_pend and go to IDLE in the same cycle.
REQ-026 Gate counter gcnt (8 bit): gate_start=1 loads gcnt <= gate_len (this retriggers if already active); otherwise gcnt decrements while nonzero. gate_active = (gcnt != 0), registered; gate_len=0 therefore never asserts.
REQ-027 The gate counter runs independently of enable.
REQ-028 Precedence within a cycle: rst > phase_sync > wrap-apply > normal update.

Reset
REQ-029 While rst=1 at a clock edge, all of the following take effect: acc=0, inc=DEFAULT_INC, inc_pend=0, state=IDLE, gcnt=0, phase=0, phase_valid=0, gate_active=0, inc_ready=0.
REQ-030 inc_ready=1 on the first cycle after rst deasserts.
REQ-031 A reset while in PENDING discards inc_pend.

Verification
REQ-032 Parameter override for all benches: ACC_WIDTH=8, PHASE_BITS=5, DEFAULT_INC=16, phase_offset=0, invert=0, unless stated otherwise.
REQ-033 Free run: enable=1 after reset -> phase follows 0,0,2,4,...,30,0 (first value after 1-cycle latency); acc wraps every 16 cycles; phase_valid=1 from the cycle after enable.
REQ-034 Frequency change: offer inc_data=32 at acc=48 -> inc_ready drops the next cycle; inc stays 16 until the wrap (acc 240->0); steps of 32 (phase +4) thereafter; inc_ready=1 after the wrap.
REQ-035 Offset/invert: phase_offset=3, invert=1 at acc=0 -> phase=19; at acc=248 -> phase=(31+3+16) mod 32=18.
REQ-036 Sync override: phase_sync while PENDING with inc_pend=64 and enable=0 -> acc=0, inc=64, state IDLE next cycle; phase then advances by 8 per cycle once enable=1.
REQ-037 Gate: gate_len=10, gate_start pulsed -> gate_active high for exactly 10 cycles; a re-pulse at count 3 extends to 10 more; gate_len=0 -> never high.
REQ-038 Reset mid-operation: rst asserted in PENDING with gate_active=1 -> the next cycle shows all outputs 0, inc=16, and inc_ready=1 after release.
